// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// and raises halt or error status, with a bounded wait on memory handshakes.
module multicycle_control_unit #(
  parameter int unsigned HALT_CODE   = 10,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic            bcond,
  input  logic [XLEN-1:0] x17,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_rw,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op_sel,
  output logic            reg_write,
  output logic [1:0]      wb_sel,
  output logic [2:0]      state,
  output logic            is_halted,
  output logic [1:0]      error_code
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic             TO_EN    = (MEM_TIMEOUT > 0);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       err_q, err_d;
  logic             timeout_c;

  // State, wait counter and latched error cause
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign state     = state_q;
  assign timeout_c = TO_EN && (wait_q == CNT_LAST);

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    wait_d     = wait_q;
    mem_req    = 1'b0;
    mem_rw     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op_sel = 2'd0;
    reg_write  = 1'b0;
    wb_sel     = 2'd0;
    is_halted  = 1'b0;
    error_code = ERR_NONE;

    unique case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_ID: begin
        alu_src_b = 2'd2;
        unique case (opcode)
          OP_ECALL: begin
            if (x17 == XLEN'(HALT_CODE)) begin
              state_d = S_HALT;
            end else begin
              pc_write = 1'b1;
              pc_src   = 2'd2;
              state_d  = S_IF;
            end
          end
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: state_d = S_EX;
          default: begin
            state_d = S_ERR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_EX: begin
        state_d = S_IF;
        unique case (opcode)
          OP_R, OP_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = (opcode == OP_I) ? 2'd2 : 2'd0;
            alu_op_sel = 2'd2;
            state_d    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op_sel = 2'd1;
            pc_write   = 1'b1;
            pc_src     = bcond ? 2'd1 : 2'd2;
          end
          OP_JAL: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_src    = 2'd1;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_rw  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        pc_write  = 1'b1;
        pc_src    = 2'd2;
        state_d   = S_IF;
      end
      S_HALT: is_halted = 1'b1;
      S_ERR:  error_code = err_q;
      default: state_d = S_IF;
    endcase

    // Count stalled request cycles; saturate so a disabled timeout never wraps
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready && (wait_q != '1)) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed per-cycle vectors are
// queued by the stimulus process and checked by an independent monitor.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'h7F;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq;
    logic       mrw;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] wbs;
    logic       hlt;
    logic [1:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic        bcond = 1'b0;
  logic [31:0] x17 = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_rw, iord, ir_write, pc_write, alu_src_a, reg_write, is_halted;
  logic [1:0]  pc_src, alu_src_b, alu_op_sel, wb_sel, error_code;
  logic [2:0]  state;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.HALT_CODE(10), .XLEN(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17(x17),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_rw(mem_rw), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
    .is_halted(is_halted), .error_code(error_code)
  );

  // Hand-built expected vectors for each kind of cycle
  function automatic exp_t e_if(input logic irw);
    exp_t e = '0;
    e.st = 3'd0; e.mreq = 1'b1; e.irw = irw;
    return e;
  endfunction

  function automatic exp_t e_id(input logic pcw);
    exp_t e = '0;
    e.st = 3'd1; e.asb = 2'd2; e.pcw = pcw; e.pcs = pcw ? 2'd2 : 2'd0;
    return e;
  endfunction

  function automatic exp_t e_ex(input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                input logic pcw, input logic [1:0] pcs, input logic rw,
                                input logic [1:0] wbs);
    exp_t e = '0;
    e.st = 3'd2; e.asa = asa; e.asb = asb; e.aop = aop;
    e.pcw = pcw; e.pcs = pcs; e.rw = rw; e.wbs = wbs;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic mrw, input logic pcw);
    exp_t e = '0;
    e.st = 3'd3; e.mreq = 1'b1; e.iord = 1'b1; e.mrw = mrw;
    e.pcw = pcw; e.pcs = pcw ? 2'd2 : 2'd0;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [1:0] wbs);
    exp_t e = '0;
    e.st = 3'd4; e.rw = 1'b1; e.wbs = wbs; e.pcw = 1'b1; e.pcs = 2'd2;
    return e;
  endfunction

  function automatic exp_t e_halt();
    exp_t e = '0;
    e.st = 3'd5; e.hlt = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_err(input logic [1:0] code);
    exp_t e = '0;
    e.st = 3'd6; e.err = code;
    return e;
  endfunction

  // One cycle: drive inputs shortly after the edge and queue what must be seen
  task automatic step(input logic [6:0] op, input logic bc, input logic [31:0] x,
                      input logic rdy, input logic rst, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    opcode = op; bcond = bc; x17 = x; mem_ready = rdy; reset = rst;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare every queued expectation against the live outputs
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{state, mem_req, mem_rw, iord, ir_write, pc_write, pc_src, alu_src_a,
            alu_src_b, alu_op_sel, reg_write, wb_sel, is_halted, error_code};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got st=%0d mreq=%b rw=%b iord=%b irw=%b pcw=%b pcs=%0d asa=%b asb=%0d aop=%0d regw=%b wbs=%0d hlt=%b err=%0d ; need st=%0d mreq=%b rw=%b iord=%b irw=%b pcw=%b pcs=%0d asa=%b asb=%0d aop=%0d regw=%b wbs=%0d hlt=%b err=%0d",
                 nm, $time, a.st, a.mreq, a.mrw, a.iord, a.irw, a.pcw, a.pcs, a.asa, a.asb,
                 a.aop, a.rw, a.wbs, a.hlt, a.err, e.st, e.mreq, e.mrw, e.iord, e.irw, e.pcw,
                 e.pcs, e.asa, e.asb, e.aop, e.rw, e.wbs, e.hlt, e.err);
      end
    end
  end

  initial begin
    // Held in reset, then released
    step(OP_R, 0, 0, 1, 0, e_if(1), "reset_if");
    step(OP_R, 0, 0, 1, 0, e_if(1), "reset_hold");
    step(OP_R, 0, 0, 1, 1, e_if(1), "rel_if");

    // R-type
    step(OP_R, 0, 0, 1, 1, e_id(0), "r_id");
    step(OP_R, 0, 0, 1, 1, e_ex(1, 2'd0, 2'd2, 0, 2'd0, 0, 2'd0), "r_ex");
    step(OP_R, 0, 0, 1, 1, e_wb(2'd0), "r_wb");
    // I-type
    step(OP_I, 0, 0, 1, 1, e_if(1), "i_if");
    step(OP_I, 0, 0, 1, 1, e_id(0), "i_id");
    step(OP_I, 0, 0, 1, 1, e_ex(1, 2'd2, 2'd2, 0, 2'd0, 0, 2'd0), "i_ex");
    step(OP_I, 0, 0, 1, 1, e_wb(2'd0), "i_wb");
    // LOAD with three wait cycles; ready in the last allowed cycle beats the timeout
    step(OP_LOAD, 0, 0, 1, 1, e_if(1), "ld_if");
    step(OP_LOAD, 0, 0, 1, 1, e_id(0), "ld_id");
    step(OP_LOAD, 0, 0, 1, 1, e_ex(1, 2'd2, 2'd0, 0, 2'd0, 0, 2'd0), "ld_ex");
    for (int i = 0; i < 3; i++) step(OP_LOAD, 0, 0, 0, 1, e_mem(0, 0), "ld_mem_wait");
    step(OP_LOAD, 0, 0, 1, 1, e_mem(0, 0), "ld_mem_done");
    step(OP_LOAD, 0, 0, 1, 1, e_wb(2'd1), "ld_wb");
    // STORE, with one fetch stall first
    step(OP_STORE, 0, 0, 0, 1, e_if(0), "st_if_stall");
    step(OP_STORE, 0, 0, 1, 1, e_if(1), "st_if");
    step(OP_STORE, 0, 0, 1, 1, e_id(0), "st_id");
    step(OP_STORE, 0, 0, 1, 1, e_ex(1, 2'd2, 2'd0, 0, 2'd0, 0, 2'd0), "st_ex");
    step(OP_STORE, 0, 0, 1, 1, e_mem(1, 1), "st_mem");
    // Branches taken / not taken
    step(OP_BRANCH, 1, 0, 1, 1, e_if(1), "bt_if");
    step(OP_BRANCH, 1, 0, 1, 1, e_id(0), "bt_id");
    step(OP_BRANCH, 1, 0, 1, 1, e_ex(1, 2'd0, 2'd1, 1, 2'd1, 0, 2'd0), "bt_ex");
    step(OP_BRANCH, 0, 0, 1, 1, e_if(1), "bn_if");
    step(OP_BRANCH, 0, 0, 1, 1, e_id(0), "bn_id");
    step(OP_BRANCH, 0, 0, 1, 1, e_ex(1, 2'd0, 2'd1, 1, 2'd2, 0, 2'd0), "bn_ex");
    // JAL / JALR; mem_ready is ignored in ID/EX
    step(OP_JAL, 0, 0, 1, 1, e_if(1), "jal_if");
    step(OP_JAL, 0, 0, 0, 1, e_id(0), "jal_id");
    step(OP_JAL, 0, 0, 0, 1, e_ex(0, 2'd0, 2'd0, 1, 2'd1, 1, 2'd2), "jal_ex");
    step(OP_JALR, 0, 0, 1, 1, e_if(1), "jalr_if");
    step(OP_JALR, 0, 0, 1, 1, e_id(0), "jalr_id");
    step(OP_JALR, 0, 0, 1, 1, e_ex(1, 2'd2, 2'd0, 1, 2'd0, 1, 2'd2), "jalr_ex");
    // Non-halting ECALL
    step(OP_ECALL, 0, 9, 1, 1, e_if(1), "ecall9_if");
    step(OP_ECALL, 0, 9, 1, 1, e_id(1), "ecall9_id");
    // Illegal opcode -> sticky ERR code 1
    step(OP_BAD, 0, 0, 1, 1, e_if(1), "bad_if");
    step(OP_BAD, 0, 0, 1, 1, e_id(0), "bad_id");
    for (int i = 0; i < 3; i++) step(OP_R, 0, 0, 1, 1, e_err(2'd1), "bad_err");
    step(OP_R, 0, 0, 1, 0, e_if(1), "bad_reset");
    step(OP_STORE, 0, 0, 1, 1, e_if(1), "to_if");
    // STORE with memory never ready -> timeout after four request cycles
    step(OP_STORE, 0, 0, 1, 1, e_id(0), "to_id");
    step(OP_STORE, 0, 0, 1, 1, e_ex(1, 2'd2, 2'd0, 0, 2'd0, 0, 2'd0), "to_ex");
    for (int i = 0; i < 4; i++) step(OP_STORE, 0, 0, 0, 1, e_mem(1, 0), "to_mem_wait");
    for (int i = 0; i < 3; i++) step(OP_STORE, 0, 0, 1, 1, e_err(2'd2), "to_err");
    step(OP_LOAD, 0, 0, 0, 0, e_if(0), "to_reset");
    // Async reset in the middle of a LOAD memory wait
    step(OP_LOAD, 0, 0, 1, 1, e_if(1), "ar_if");
    step(OP_LOAD, 0, 0, 1, 1, e_id(0), "ar_id");
    step(OP_LOAD, 0, 0, 1, 1, e_ex(1, 2'd2, 2'd0, 0, 2'd0, 0, 2'd0), "ar_ex");
    step(OP_LOAD, 0, 0, 0, 1, e_mem(0, 0), "ar_mem_wait");
    step(OP_LOAD, 0, 0, 0, 0, e_if(0), "ar_async");
    step(OP_LOAD, 0, 0, 0, 1, e_if(0), "ar_release");
    // Halting ECALL stays in HALT
    step(OP_ECALL, 0, 10, 1, 1, e_if(1), "halt_if");
    step(OP_ECALL, 0, 10, 1, 1, e_id(0), "halt_id");
    for (int i = 0; i < 20; i++) step(OP_ECALL, 0, 10, 1, 1, e_halt(), "halt_hold");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have parameter HALT_CODE, default 10: x17 value that makes ECALL halt.
REQ-002 The block SHALL have parameter XLEN, default 32: width of x17.
REQ-003 The block SHALL have parameter MEM_TIMEOUT, default 255: maximum cycles mem_req is held without mem_ready; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port opcode, input, 7 bits: inst[6:0] from the instruction register.
REQ-007 The block SHALL have port bcond, input, 1 bit: ALU branch-taken flag.
REQ-008 The block SHALL have port x17, input, XLEN bits: register x17 value.
REQ-009 The block SHALL have port mem_ready, input, 1 bit: memory completes the current request this cycle.
REQ-010 The block SHALL have port mem_req, output, 1 bit: memory access request.
REQ-011 The block SHALL have port mem_rw, output, 1 bit: 1 = write, 0 = read.
REQ-012 The block SHALL have port iord, output, 1 bit: memory address select, 0 = PC, 1 = ALUOut.
REQ-013 The block SHALL have port ir_write, output, 1 bit: latch instruction register.
REQ-014 The block SHALL have port pc_write, output, 1 bit: update PC.
REQ-015 The block SHALL have port pc_src, output, 2 bits: next-PC select, 0 = ALU result, 1 = ALUOut, 2 = PC+4.
REQ-016 The block SHALL have port alu_src_a, output, 1 bit: ALU operand A select, 0 = PC, 1 = rs1.
REQ-017 The block SHALL have port alu_src_b, output, 2 bits: ALU operand B select, 0 = rs2, 2 = imm.
REQ-018 The block SHALL have port alu_op_sel, output, 2 bits: ALU operation, 0 = add, 1 = branch compare, 2 = funct-decoded.
REQ-019 The block SHALL have port reg_write, output, 1 bit: register file write enable.
REQ-020 The block SHALL have port wb_sel, output, 2 bits: write-back select, 0 = ALUOut, 1 = MDR, 2 = PC+4.
REQ-021 The block SHALL have port state, output, 3 bits: current state.
REQ-022 The block SHALL have port is_halted, output, 1 bit: halted flag.
REQ-023 The block SHALL have port error_code, output, 2 bits: 0 = none, 1 = illegal opcode, 2 = memory timeout.

Function
REQ-024 The state register SHALL use the encoding IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6; all other outputs SHALL be combinational from state, opcode, bcond, x17 and mem_ready.
REQ-025 Every strobe or select output not listed for a state SHALL be 0 in that state.
REQ-026 In IF the block SHALL drive mem_req=1 and iord=0; on mem_ready=1 it SHALL drive ir_write=1 and go to ID; otherwise it SHALL stay in IF.
REQ-027 In ID the block SHALL drive alu_src_a=0, alu_src_b=2, alu_op_sel=0, computing the branch/JAL target into ALUOut.
REQ-028 ID decode: ECALL (1110011) with x17==HALT_CODE SHALL go to HALT; ECALL otherwise SHALL drive pc_write=1, pc_src=2 and go to IF.
REQ-029 ID decode: R (0110011), I (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111) and JALR (1100111) SHALL go to EX; any other opcode SHALL go to ERR with error_code=1.
REQ-030 EX for R or I: alu_src_a=1, alu_src_b=0 (R) or 2 (I), alu_op_sel=2; next state WB.
REQ-031 EX for LOAD or STORE: alu_src_a=1, alu_src_b=2, alu_op_sel=0; next state MEM.
REQ-032 EX for BRANCH: alu_src_a=1, alu_src_b=0, alu_op_sel=1, pc_write=1, pc_src=1 if bcond else 2; next state IF.
REQ-033 EX for JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1; next state IF.
REQ-034 EX for JALR: alu_src_a=1, alu_src_b=2, alu_op_sel=0, reg_write=1, wb_sel=2, pc_write=1, pc_src=0; next state IF.
REQ-035 MEM SHALL drive mem_req=1, iord=1, mem_rw=1 for STORE and 0 for LOAD; it SHALL hold until mem_ready=1.
REQ-036 On mem_ready in MEM, LOAD SHALL go to WB; STORE SHALL drive pc_write=1, pc_src=2 and go to IF.
REQ-037 WB SHALL drive reg_write=1, wb_sel=1 for LOAD and 0 otherwise, pc_write=1, pc_src=2; next state IF.
REQ-038 mem_ready SHALL be ignored outside IF and MEM.
REQ-039 The wait counter SHALL count cycles with mem_req=1 and mem_ready=0, and SHALL clear on every state change.
REQ-040 When MEM_TIMEOUT>0 and a request has been held MEM_TIMEOUT cycles without mem_ready, the next state SHALL be ERR with error_code=2; mem_ready arriving in the last allowed cycle SHALL win over the timeout.
REQ-041 With zero-wait memory, CPI SHALL be: R/I 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3, non-halting ECALL 2.
REQ-042 HALT SHALL drive is_halted=1 with all strobes 0, and ERR SHALL hold error_code with all strobes 0; both states SHALL be sticky until reset.

Reset
REQ-043 While reset=0, the block SHALL immediately force state=IF, wait counter=0, error_code=0 and is_halted=0, including mid-request.
REQ-044 On the first rising edge after reset=1, the block SHALL be in IF with mem_req=1 and iord=0.

Verification
REQ-045 R-type, mem_ready=1 -> states IF,ID,EX,WB,IF; reg_write=1 only in WB; pc_write=1, pc_src=2 in WB.
REQ-046 LOAD, mem_ready delayed 3 cycles in MEM -> mem_req=1, iord=1, mem_rw=0 for 4 cycles, then WB with wb_sel=1.
REQ-047 BRANCH with bcond=1 -> EX has pc_write=1, pc_src=1; with bcond=0 -> pc_src=2; each 3 cycles.
REQ-048 ECALL with x17=10 -> HALT, is_halted=1 stays high for 20 cycles with all strobes 0; with x17=9 -> back to IF after 2 cycles.
REQ-049 MEM_TIMEOUT=4, mem_ready=0 -> mem_req high 4 cycles, then ERR, error_code=2; opcode 7'h7F -> ERR, error_code=1.
REQ-050 reset=0 during a MEM wait -> state=0 immediately without a clock edge; after release -> mem_req=1, iord=0.
